// File: rtl/pwm_pkg.sv
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync.sv
module pwm_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              hist_q, hist_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
    hist_d  = chain_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
      hist_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      hist_q  <= hist_d;
    end
  end

  assign sync = chain_q[STAGES-1];
  assign rise = sync & ~hist_q;
  assign fall = ~sync & hist_q;

endmodule

// File: rtl/pwm_capture.sv
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = PWM_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_pwm_in,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_ovf
);

  logic sync, rise, fall;

  pwm_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (i_wb_clk),
    .rst_n (i_wb_rst_n),
    .d     (i_pwm_in),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);
    shadow_d = shadow_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    ovf_set  = 1'b0;

    if (!i_en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      shadow_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          cnt_d = '0;
          if (rise) begin
            state_d = ST_HIGH;
            cnt_d   = WIDTH'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            shadow_d = cnt_q;
            state_d  = ST_LOW;
          end else if (sync && cnt_q == '1) begin
            // without a fall, sync is necessarily still high in this state
            ovf_set = 1'b1;
            state_d = ST_ARM;
          end
        end
        ST_LOW: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = shadow_q;
            valid_d  = 1'b1;
            cnt_d    = WIDTH'(1);
            state_d  = ST_HIGH;
          end else if (cnt_q == '1) begin
            ovf_set = 1'b1;
            state_d = ST_ARM;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (ovf_set)    ovf_d = 1'b1;
    else if (i_clr) ovf_d = 1'b0;
    else            ovf_d = ovf_q;
  end

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n, en, clr, pwm;
  logic [W-1:0] period, high;
  logic         valid, ovf;

  always #5 clk = ~clk;

  pwm_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_en       (en),
    .i_clr      (clr),
    .i_pwm_in   (pwm),
    .o_period   (period),
    .o_high     (high),
    .o_valid    (valid),
    .o_ovf      (ovf)
  );

  // Index of the most recent rising clock edge.
  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int at_edge;
    int per;
    int hi;
  } exp_t;

  exp_t sb[$];
  bit   rst_at[int];
  bit   set_at[int];
  bit   clr_at[int];

  int  checks   = 0;
  int  failures = 0;
  bit  done     = 1'b0;
  bit  cur_en   = 1'b0;

  // Reference model: timestamps of input edges, in units of driven samples.
  bit  m_prev   = 1'b0;
  bit  m_active = 1'b0;
  int  m_rise   = 0;
  int  m_fall   = 0;

  // A sample driven after edge s is acted on by the DUT at edge s+3.
  localparam int LAT = 3;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, ecount, act, req);
    end
  endtask

  task automatic model_step(input int s, input bit l);
    bit r, f;
    r = l & ~m_prev;
    f = ~l & m_prev;
    if (!m_active) begin
      if (r) begin
        m_active = 1'b1;
        m_rise   = s;
      end
    end else if (r) begin
      sb.push_back('{s + LAT, s - m_rise, m_fall - m_rise});
      m_rise = s;
    end else if (f) begin
      m_fall = s;
    end else if (s - m_rise == 65535) begin
      set_at[s + LAT] = 1'b1;
      m_active = 1'b0;
    end
  endtask

  task automatic cyc(input bit lvl, input bit e, input bit r, input bit c);
    int s;
    @(posedge clk);
    #1;
    s     = ecount;
    pwm   = lvl;
    en    = e;
    rst_n = r;
    clr   = c;
    if (c) clr_at[s + 1] = 1'b1;
    if (!r) begin
      rst_at[s + 1] = 1'b1;
      while (sb.size() > 0 && sb[$].at_edge >= s + 1) void'(sb.pop_back());
      for (int k = 1; k <= LAT; k++) if (set_at.exists(s + k)) set_at.delete(s + k);
      m_active = 1'b0;
      m_prev   = 1'b0;
    end else begin
      if (e) model_step(s, lvl);
      else   m_active = 1'b0;
      m_prev = lvl;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h) cyc(1'b1, cur_en, 1'b1, 1'b0);
      repeat (l) cyc(1'b0, cur_en, 1'b1, 1'b0);
    end
  endtask

  task automatic set_en(input bit e);
    repeat (4) cyc(1'b0, cur_en, 1'b1, 1'b0);
    cur_en = e;
    repeat (4) cyc(1'b0, cur_en, 1'b1, 1'b0);
  endtask

  // Monitor: per-cycle output expectations and scoreboard pops.
  int exp_p   = 0;
  int exp_h   = 0;
  bit exp_ovf = 1'b0;

  always @(negedge clk) begin
    int e;
    e = ecount;
    if (!done && e >= 1) begin
      if (rst_at.exists(e)) begin
        exp_p   = 0;
        exp_h   = 0;
        exp_ovf = 1'b0;
        chk("rst_valid", int'(valid), 0);
      end else begin
        if (set_at.exists(e))      exp_ovf = 1'b1;
        else if (clr_at.exists(e)) exp_ovf = 1'b0;
        while (sb.size() > 0 && sb[0].at_edge < e) begin
          chk("missed_valid", 0, 1);
          exp_p = sb[0].per;
          exp_h = sb[0].hi;
          void'(sb.pop_front());
        end
        if (valid) begin
          if (sb.size() == 0 || sb[0].at_edge != e) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            exp_p = sb[0].per;
            exp_h = sb[0].hi;
            void'(sb.pop_front());
          end
        end
      end
      chk("period", int'(period), exp_p);
      chk("high", int'(high), exp_h);
      chk("ovf", int'(ovf), int'(exp_ovf));
    end
  end

  initial begin
    pwm       = 1'b0;
    en        = 1'b0;
    clr       = 1'b0;
    rst_n     = 1'b0;
    rst_at[1] = 1'b1;

    // Reset with a toggling input, then enable low.
    repeat (8)  cyc(bit'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    repeat (12) cyc(bit'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    set_en(1'b1);

    // Even, odd, wide and narrow-duty waveforms.
    wave(2, 2, 8);
    wave(3, 2, 6);
    wave(51, 50, 3);
    wave(1, 99, 3);
    wave(1, 1, 4);

    // Random periods.
    for (int i = 0; i < 20; i++)
      wave(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 1);

    // Held-high input times out; clear; clean 10-cycle waveform afterwards.
    repeat (4) cyc(1'b0, cur_en, 1'b1, 1'b0);
    repeat (70000) cyc(1'b1, cur_en, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, cur_en, 1'b1, 1'b0);
    cyc(1'b0, cur_en, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, cur_en, 1'b1, 1'b0);
    wave(5, 5, 4);

    // Disable while low, scribble on the input, re-enable.
    wave(3, 4, 3);
    set_en(1'b0);
    repeat (10) cyc(bit'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    set_en(1'b1);
    wave(3, 4, 3);

    // One-cycle reset in the middle of a high phase.
    wave(4, 4, 3);
    repeat (2) cyc(1'b1, cur_en, 1'b1, 1'b0);
    cyc(1'b1, cur_en, 1'b0, 1'b0);
    cyc(1'b1, cur_en, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, cur_en, 1'b1, 1'b0);
    wave(4, 4, 4);

    repeat (10) cyc(1'b0, cur_en, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
